// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a CPU port and a loader/debug port share one
// synchronous single-port memory. Writes finish in the grant cycle. Reads
// spend one extra RESP cycle returning data to the owning port.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              lastOwner_q, lastOwner_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] cpuRdata_q, cpuRdata_d;
    logic [DATA_W-1:0] ldrRdata_q, ldrRdata_d;
    logic              grantCpu, grantLdr;

    // Arbitration, memory command drive and FSM next state. Grants are held off
    // while reset is asserted so nothing leaks out combinationally during reset.
    always_comb begin
        state_d     = state_q;
        lastOwner_d = lastOwner_q;
        owner_d     = owner_q;
        grantCpu    = 1'b0;
        grantLdr    = 1'b0;
        cpu_rvalid  = 1'b0;
        ldr_rvalid  = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state_q)
            IDLE: begin
                if (!reset) begin
                    if (cpu_req && (!ldr_req || lastOwner_q)) begin
                        grantCpu = 1'b1;
                    end else if (ldr_req) begin
                        grantLdr = 1'b1;
                    end
                end
                if (grantCpu) begin
                    mem_en      = 1'b1;
                    mem_we      = cpu_we;
                    mem_addr    = cpu_addr;
                    mem_wdata   = cpu_wdata;
                    lastOwner_d = 1'b0;
                    if (!cpu_we) begin
                        state_d = RESP;
                        owner_d = 1'b0;
                    end
                end else if (grantLdr) begin
                    mem_en      = 1'b1;
                    mem_we      = ldr_we;
                    mem_addr    = ldr_addr;
                    mem_wdata   = ldr_wdata;
                    lastOwner_d = 1'b1;
                    if (!ldr_we) begin
                        state_d = RESP;
                        owner_d = 1'b1;
                    end
                end
            end
            RESP: begin
                cpu_rvalid = !owner_q;
                ldr_rvalid = owner_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data registers. The next-state value doubles as the output so the
    // memory word is visible on rdata during the rvalid cycle itself.
    always_comb begin
        cpuRdata_d = cpu_rvalid ? mem_rdata : cpuRdata_q;
        ldrRdata_d = ldr_rvalid ? mem_rdata : ldrRdata_q;
    end

    // State registers. last_owner starts at 1 so the CPU wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lastOwner_q <= 1'b1;
            owner_q     <= 1'b0;
            cpuRdata_q  <= '0;
            ldrRdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            lastOwner_q <= lastOwner_d;
            owner_q     <= owner_d;
            cpuRdata_q  <= cpuRdata_d;
            ldrRdata_q  <= ldrRdata_d;
        end
    end

    assign cpu_gnt   = grantCpu;
    assign ldr_gnt   = grantLdr;
    assign cpu_rdata = cpuRdata_d;
    assign ldr_rdata = ldrRdata_d;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width of the memory port.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cpu_req  input  1  CPU requester (port 0) requests an access.
REQ-006 cpu_we  input  1  port 0: 1 = write, 0 = read.
REQ-007 cpu_addr  input  ADDR_W  port 0 address.
REQ-008 cpu_wdata  input  DATA_W  port 0 write data.
REQ-009 cpu_gnt  output  1  port 0 request accepted this cycle.
REQ-010 cpu_rvalid  output  1  port 0 read data valid this cycle.
REQ-011 cpu_rdata  output  DATA_W  port 0 read data.
REQ-012 ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_gnt, ldr_rvalid, ldr_rdata  same directions, widths and meanings as REQ-005..011, for the loader/debug requester (port 1).
REQ-013 mem_en  output  1  memory command strobe.
REQ-014 mem_we  output  1  memory write enable, qualified by mem_en.
REQ-015 mem_addr  output  ADDR_W  memory address.
REQ-016 mem_wdata  output  DATA_W  memory write data.
REQ-017 mem_rdata  input  DATA_W  synchronous memory read data, valid one cycle after a read command.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 The block SHALL implement a 2-state FSM: IDLE and RESP.
REQ-020 In IDLE with at least one req high, the block SHALL select one winner and, in the same cycle and combinationally, drive mem_en=1, mem_we/mem_addr/mem_wdata from the winner, and that port's gnt=1.
REQ-021 Only one gnt SHALL be high in any cycle; gnt SHALL never be high in RESP.
REQ-022 Arbitration SHALL be round-robin: a last_owner register selects the port not most recently granted when both req are high; a single requester SHALL always win.
REQ-023 last_owner SHALL update to the granted port on every grant.
REQ-024 A granted write SHALL complete in the grant cycle; FSM SHALL stay in IDLE; no rvalid is produced.
REQ-025 A granted read SHALL move the FSM to RESP and record the owner port.
REQ-026 In RESP the block SHALL pulse the owner's rvalid for exactly one cycle, drive mem_en=0, and return to IDLE next cycle.
REQ-027 Each port's rdata SHALL be a register loaded from mem_rdata on that port's rvalid cycle and SHALL hold its value until the next rvalid for that port.
REQ-028 During the rvalid cycle, rdata SHALL already equal mem_rdata: mux-through or equivalent bypass is required.
REQ-029 A requester SHALL hold req, we, addr and wdata stable until gnt. The block SHALL NOT check this.
REQ-030 req held high after gnt SHALL be treated as a new request: back-to-back writes from one port complete one per cycle; reads complete one per two cycles.
REQ-031 Outside a grant, mem_en=0, mem_we=0, and mem_addr/mem_wdata SHALL be 0.

Reset
REQ-032 On reset the block SHALL enter IDLE, with last_owner=1 so port 0 wins the first contention, both rdata=0 and all gnt/rvalid/mem_en=0.
REQ-033 Reset asserted in RESP SHALL abort the read: no rvalid is issued and rdata is cleared.
REQ-034 The first grant SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-035 Port 0 read addr 0x10, memory word 0xDEADBEEF -> cpu_gnt on cycle N, cpu_rvalid with cpu_rdata=0xDEADBEEF on N+1, busy=1 on N+1 only.
REQ-036 Both ports read simultaneously after reset -> port 0 granted first, port 1 granted on the first IDLE cycle after port 0's RESP, rvalid at t+1 and t+3.
REQ-037 Port 1 write 0x0000_00AA to 0x20 while port 0 idle -> mem_en=mem_we=1, mem_addr=0x20, mem_wdata=0xAA in grant cycle; no rvalid; next cycle free.
REQ-038 Both ports hold req for 8 cycles, all writes -> grants alternate 0,1,0,1,...; never two gnt in one cycle.
REQ-039 Reset asserted during RESP -> no rvalid, rdata=0, IDLE afterward; a new read after release completes normally.
REQ-040 Port 0 reads 0x11111111, then port 1 reads 0x22222222 -> cpu_rdata still 0x11111111 after port 1's rvalid.
